// File: rtl/draw_player_ctrl_if.sv
// VGA stream bundle passed between draw stages: timing counters, sync/blank strobes and pixel colour.
interface vga_if;
   logic [10:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [10:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;

   modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
   modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/draw_player_ctrl.sv
// Player mover with tick-paced acceleration, collision blocking and screen clamping,
// plus a one-clock sprite overlay stage whose position is latched at vertical blank.
module draw_player_ctrl #(
   parameter int          PLAYER_SIZE = 16,
   parameter int          SCREEN_W    = 800,
   parameter int          SCREEN_H    = 600,
   parameter int          START_X     = 32,
   parameter int          START_Y     = 32,
   parameter int          TICK_DIV    = 500000,
   parameter int          MAX_SPEED   = 4,
   parameter int          ACCEL_TICKS = 8,
   parameter logic [11:0] COLOR       = 12'hF00
) (
   input  logic       clk,
   input  logic       rst,
   vga_if.in          in,
   vga_if.out         out,
   input  logic       move_up,
   input  logic       move_down,
   input  logic       move_right,
   input  logic       move_left,
   input  logic       collision_up,
   input  logic       collision_down,
   input  logic       collision_right,
   input  logic       collision_left,
   output logic [9:0] xpos,
   output logic [9:0] ypos,
   output logic [2:0] speed,
   output logic       moving
);
   localparam int CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HOLD_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
   localparam logic signed [10:0] X_MIN = 11'(PLAYER_SIZE);
   localparam logic signed [10:0] X_MAX = 11'(SCREEN_W - PLAYER_SIZE - 1);
   localparam logic signed [10:0] Y_MIN = 11'(PLAYER_SIZE);
   localparam logic signed [10:0] Y_MAX = 11'(SCREEN_H - PLAYER_SIZE - 1);

   typedef enum logic [1:0] {IDLE, ACCEL, CRUISE} state_t;
   typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_RIGHT, DIR_LEFT} dir_t;

   state_t             state, state_nxt;
   dir_t               dir, dir_cur, dir_cur_nxt;
   logic [CNT_W-1:0]   tick_cnt;
   logic               tick;
   logic               blocked;
   logic [HOLD_W-1:0]  hold, hold_nxt;
   logic [2:0]         speed_nxt;
   logic [2:0]         step;
   logic signed [10:0] x_new, y_new, step_ext;
   logic [9:0]         xpos_nxt, ypos_nxt;
   logic [9:0]         xdisp, ydisp;
   logic               vblnk_q;
   logic               in_win;
   logic [11:0]        rgb_nxt;

   assign tick   = (tick_cnt == CNT_W'(TICK_DIV - 1));
   assign moving = (state != IDLE);

   always_comb begin
      dir     = DIR_NONE;
      blocked = 1'b1;
      if (move_up) begin
         dir     = DIR_UP;
         blocked = collision_up;
      end else if (move_down) begin
         dir     = DIR_DOWN;
         blocked = collision_down;
      end else if (move_right) begin
         dir     = DIR_RIGHT;
         blocked = collision_right;
      end else if (move_left) begin
         dir     = DIR_LEFT;
         blocked = collision_left;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      dir_cur_nxt = dir_cur;
      hold_nxt    = hold;
      speed_nxt   = speed;
      step        = 3'd0;
      if (tick) begin
         if (blocked) begin
            state_nxt   = IDLE;
            dir_cur_nxt = DIR_NONE;
            hold_nxt    = '0;
            speed_nxt   = 3'd0;
         end else if (state == IDLE || dir != dir_cur) begin
            state_nxt   = (MAX_SPEED <= 1) ? CRUISE : ACCEL;
            dir_cur_nxt = dir;
            hold_nxt    = '0;
            speed_nxt   = 3'd1;
            step        = 3'd1;
         end else if (state == ACCEL) begin
            if (hold == HOLD_W'(ACCEL_TICKS - 1)) begin
               hold_nxt  = '0;
               speed_nxt = speed + 3'd1;
               if (speed_nxt == 3'(MAX_SPEED)) state_nxt = CRUISE;
            end else begin
               hold_nxt = hold + 1'b1;
            end
            step = speed_nxt;
         end else begin
            speed_nxt = 3'(MAX_SPEED);
            step      = 3'(MAX_SPEED);
         end
      end
   end

   // Signed arithmetic lets a step past the left/top edge go negative before the clamp.
   always_comb begin
      step_ext = signed'(11'(step));
      x_new    = signed'({1'b0, xpos});
      y_new    = signed'({1'b0, ypos});
      case (dir_cur_nxt)
         DIR_UP:    y_new = y_new - step_ext;
         DIR_DOWN:  y_new = y_new + step_ext;
         DIR_RIGHT: x_new = x_new + step_ext;
         DIR_LEFT:  x_new = x_new - step_ext;
         default:   ;
      endcase
      if (x_new < X_MIN) x_new = X_MIN;
      if (x_new > X_MAX) x_new = X_MAX;
      if (y_new < Y_MIN) y_new = Y_MIN;
      if (y_new > Y_MAX) y_new = Y_MAX;
      xpos_nxt = x_new[9:0];
      ypos_nxt = y_new[9:0];
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
         state    <= IDLE;
         dir_cur  <= DIR_NONE;
         hold     <= '0;
         speed    <= 3'd0;
         xpos     <= 10'(START_X);
         ypos     <= 10'(START_Y);
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         state    <= state_nxt;
         dir_cur  <= dir_cur_nxt;
         hold     <= hold_nxt;
         speed    <= speed_nxt;
         xpos     <= xpos_nxt;
         ypos     <= ypos_nxt;
      end
   end

   // Display copy changes only at frame start, so a frame never shows a torn sprite.
   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_q <= 1'b0;
         xdisp   <= 10'(START_X);
         ydisp   <= 10'(START_Y);
      end else begin
         vblnk_q <= in.vblnk;
         if (in.vblnk && !vblnk_q) begin
            xdisp <= xpos;
            ydisp <= ypos;
         end
      end
   end

   always_comb begin
      in_win = (signed'({1'b0, in.hcount}) >= signed'(12'(xdisp)) - 12'sd1 * 12'(PLAYER_SIZE) + 12'sd1) &&
               (signed'({1'b0, in.hcount}) <= signed'(12'(xdisp)) + 12'(PLAYER_SIZE)) &&
               (signed'({1'b0, in.vcount}) >= signed'(12'(ydisp)) - 12'(PLAYER_SIZE) + 12'sd1) &&
               (signed'({1'b0, in.vcount}) <= signed'(12'(ydisp)) + 12'(PLAYER_SIZE));
      rgb_nxt = in_win ? COLOR : in.rgb;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out.vcount <= '0;
         out.vsync  <= 1'b0;
         out.vblnk  <= 1'b0;
         out.hcount <= '0;
         out.hsync  <= 1'b0;
         out.hblnk  <= 1'b0;
         out.rgb    <= '0;
      end else begin
         out.vcount <= in.vcount;
         out.vsync  <= in.vsync;
         out.vblnk  <= in.vblnk;
         out.hcount <= in.hcount;
         out.hsync  <= in.hsync;
         out.hblnk  <= in.hblnk;
         out.rgb    <= rgb_nxt;
      end
   end
endmodule

// File: tb/tb_draw_player_ctrl.sv
// Directed bench for draw_player_ctrl: reset, acceleration, direction priority, clamp,
// collision stop, vblank-latched overlay window and mid-run reset.
module tb_draw_player_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       move_up, move_down, move_right, move_left;
   logic       collision_up, collision_down, collision_right, collision_left;
   logic [9:0] xpos, ypos;
   logic [2:0] speed;
   logic       moving;
   int         checks = 0;
   int         errors = 0;
   int         phase;

   vga_if vin ();
   vga_if vout ();

   always #5 clk = ~clk;

   draw_player_ctrl #(
      .TICK_DIV   (4),
      .MAX_SPEED  (3),
      .ACCEL_TICKS(2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .in             (vin),
      .out            (vout),
      .move_up        (move_up),
      .move_down      (move_down),
      .move_right     (move_right),
      .move_left      (move_left),
      .collision_up   (collision_up),
      .collision_down (collision_down),
      .collision_right(collision_right),
      .collision_left (collision_left),
      .xpos           (xpos),
      .ypos           (ypos),
      .speed          (speed),
      .moving         (moving)
   );

   // Reference tick phase: 0 right after a tick edge, tick fires on the edge leaving 3.
   always @(posedge clk) begin
      if (rst) phase <= 0;
      else     phase <= (phase == 3) ? 0 : phase + 1;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic next_tick();
      bit hit = 1'b0;
      for (int i = 0; i < 8 && !hit; i++) begin
         @(posedge clk);
         #1;
         hit = (phase == 0);
      end
      checks++;
      if (!hit) begin
         errors++;
         $error("FAIL tick_wait: observed no tick expected tick within 8 clk");
      end
   endtask

   task automatic pixel(input logic [10:0] h, input logic [10:0] v);
      vin.hcount = h;
      vin.vcount = v;
      @(posedge clk);
      #1;
   endtask

   logic [9:0] left_x [12] = '{10'd43, 10'd42, 10'd40, 10'd38, 10'd35, 10'd32,
                               10'd29, 10'd26, 10'd23, 10'd20, 10'd17, 10'd16};
   logic [2:0] left_s [12] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3,
                               3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
   logic [9:0] right_x [6] = '{10'd33, 10'd34, 10'd36, 10'd38, 10'd41, 10'd44};
   logic [2:0] right_s [6] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3};

   initial begin
      rst = 1'b1;
      {move_up, move_down, move_right, move_left} = '0;
      {collision_up, collision_down, collision_right, collision_left} = '0;
      vin.vcount = '0; vin.hcount = '0;
      vin.vsync = 1'b0; vin.hsync = 1'b0; vin.vblnk = 1'b0; vin.hblnk = 1'b0;
      vin.rgb = 12'hABC;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_rgb", 32'(vout.rgb), 32'h0);
      check("rst_x", 32'(xpos), 32);
      check("rst_y", 32'(ypos), 32);
      check("rst_speed", 32'(speed), 0);
      check("rst_moving", 32'(moving), 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_x", 32'(xpos), 32);

      // Acceleration to cruise
      move_right = 1'b1;
      for (int i = 0; i < 6; i++) begin
         next_tick();
         check($sformatf("right_x%0d", i), 32'(xpos), 32'(right_x[i]));
         check($sformatf("right_s%0d", i), 32'(speed), 32'(right_s[i]));
      end
      check("cruise_moving", 32'(moving), 1);

      // Direction change and priority
      move_up = 1'b1;
      next_tick();
      check("up_y", 32'(ypos), 31);
      check("up_x", 32'(xpos), 44);
      check("up_speed", 32'(speed), 1);
      move_right = 1'b0;
      move_left  = 1'b1;
      next_tick();
      check("prio_y", 32'(ypos), 30);
      check("prio_x", 32'(xpos), 44);

      // Leftward run into the clamp, then collision stop
      move_up = 1'b0;
      for (int i = 0; i < 12; i++) begin
         next_tick();
         check($sformatf("left_x%0d", i), 32'(xpos), 32'(left_x[i]));
         check($sformatf("left_s%0d", i), 32'(speed), 32'(left_s[i]));
      end
      next_tick();
      check("clamp_hold_x", 32'(xpos), 16);
      check("clamp_hold_s", 32'(speed), 3);
      collision_left = 1'b1;
      next_tick();
      check("coll_x", 32'(xpos), 16);
      check("coll_speed", 32'(speed), 0);
      check("coll_moving", 32'(moving), 0);

      // Overlay still at the old display position (32,32)
      vin.rgb = 12'h0AB;
      vin.hsync = 1'b1;
      pixel(11'd48, 11'd32);
      check("ov_edge_in", 32'(vout.rgb), 32'hF00);
      check("ov_hcount_lat", 32'(vout.hcount), 48);
      check("ov_hsync_lat", 32'(vout.hsync), 1);
      pixel(11'd49, 11'd32);
      check("ov_edge_out", 32'(vout.rgb), 32'h0AB);
      pixel(11'd17, 11'd32);
      check("ov_left_in", 32'(vout.rgb), 32'hF00);
      pixel(11'd16, 11'd32);
      check("ov_left_out", 32'(vout.rgb), 32'h0AB);
      pixel(11'd32, 11'd48);
      check("ov_bot_in", 32'(vout.rgb), 32'hF00);
      pixel(11'd32, 11'd49);
      check("ov_bot_out", 32'(vout.rgb), 32'h0AB);

      // Vblank rise moves the window to (16,30)
      vin.vblnk = 1'b1;
      @(posedge clk);
      #1;
      pixel(11'd48, 11'd32);
      check("vb_old_win", 32'(vout.rgb), 32'h0AB);
      pixel(11'd32, 11'd30);
      check("vb_new_in", 32'(vout.rgb), 32'hF00);
      pixel(11'd33, 11'd30);
      check("vb_new_out", 32'(vout.rgb), 32'h0AB);
      pixel(11'd1, 11'd30);
      check("vb_zero_in", 32'(vout.rgb), 32'hF00);
      pixel(11'd0, 11'd30);
      check("vb_zero_out", 32'(vout.rgb), 32'h0AB);

      // Cruise again, then reset mid-run
      collision_left = 1'b0;
      move_left      = 1'b0;
      move_right     = 1'b1;
      repeat (5) next_tick();
      check("cruise2_x", 32'(xpos), 25);
      check("cruise2_moving", 32'(moving), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_x", 32'(xpos), 32);
      check("mid_rst_y", 32'(ypos), 32);
      check("mid_rst_speed", 32'(speed), 0);
      check("mid_rst_moving", 32'(moving), 0);
      check("mid_rst_rgb", 32'(vout.rgb), 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("restart_before_tick", 32'(xpos), 32);
      @(posedge clk);
      #1;
      check("restart_first_tick", 32'(xpos), 33);
      check("restart_speed", 32'(speed), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end
endmodule
